// File: rtl/rv_lsu.sv
// rv_lsu: MEM-stage load/store unit in front of rv_data_mem.
// Every access is turned into doubleword-aligned reads/writes on a 64-bit
// port. Sub-doubleword stores are read-modify-write because the memory has
// no byte enables. Misaligned requests get a misalign response and never
// touch memory.
//
// Handshake: a request transfers in the cycle where req_valid and req_ready
// are both high; req_* are sampled only in that cycle. resp_valid is a
// one-cycle pulse with no back-pressure; resp_rdata and resp_misalign hold
// their value until the next response.
module rv_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [63:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] buf_q, buf_d;
  logic [63:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic        accept;
  logic        req_mis;
  logic [5:0]  sh_amt;
  logic [63:0] shifted;
  logic [63:0] ext;
  logic [63:0] lane_mask;
  logic [63:0] merged;

  assign accept = (state_q == S_IDLE) && req_valid;

  // Misalignment of the incoming request: address must be a multiple of the size
  always_comb begin
    req_mis = 1'b0;
    unique case (req_size)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = req_addr[0];
      2'b10:   req_mis = |req_addr[1:0];
      default: req_mis = |req_addr[2:0];
    endcase
  end

  // Byte-lane extraction/extension for loads and lane merge for stores
  always_comb begin
    sh_amt    = {addr_q[2:0], 3'b000};
    shifted   = mem_rd_data >> sh_amt;
    ext       = shifted;
    lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    unique case (size_q)
      2'b00: begin
        ext       = uns_q ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
        lane_mask = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        ext       = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        lane_mask = 64'h0000_0000_0000_FFFF;
      end
      2'b10: begin
        ext       = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        ext       = shifted;
        lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
    lane_mask = lane_mask << sh_amt;
    merged    = (mem_rd_data & ~lane_mask) | ((wdata_q << sh_amt) & lane_mask);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_mis)                           state_d = S_RESP;
          else if (req_we && req_size == 2'b11)  state_d = S_WR;
          else                                   state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  state_d = S_RD_DATA;
      S_RD_DATA: state_d = we_q ? S_WR : S_RESP;
      S_WR:      state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request latch, merge buffer and response registers
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    if (accept) begin
      we_d    = req_we;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      buf_d   = req_wdata;
      if (req_mis) begin
        rdata_d = 64'd0;
        mis_d   = 1'b1;
      end
    end
    if (state_q == S_RD_DATA) begin
      if (we_q) begin
        buf_d = merged;
      end else begin
        rdata_d = ext;
        mis_d   = 1'b0;
      end
    end
    if (state_q == S_WR) begin
      rdata_d = 64'd0;
      mis_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 64'd0;
      buf_q   <= 64'd0;
      rdata_q <= 64'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    req_ready     = (state_q == S_IDLE) && !rst;
    mem_rd_en     = (state_q == S_RD_REQ);
    mem_wr_en     = (state_q == S_WR);
    mem_wr_data   = (state_q == S_WR) ? buf_q : 64'd0;
    mem_addr      = (state_q == S_IDLE) ? 32'd0 : {addr_q[31:3], 3'b000};
    resp_valid    = (state_q == S_RESP);
    resp_rdata    = rdata_q;
    resp_misalign = mis_q;
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: bench for rv_lsu with a behavioural byte-array memory model.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rd_data;
  logic        mem_wr_en;
  logic [63:0] mem_wr_data;

  rv_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- data memory (64 dwords) ----------------
  logic [63:0] dmem     [64];
  logic [63:0] init_img [64];
  logic        load_img = 1'b0;
  int          wr_strobes = 0;
  int          resp_pulses = 0;

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_img[i];
    end else begin
      if (mem_rd_en) mem_rd_data <= dmem[mem_addr[8:3]];
      if (mem_wr_en) dmem[mem_addr[8:3]] <= mem_wr_data;
    end
    if (mem_wr_en)  wr_strobes  <= wr_strobes + 1;
    if (resp_valid) resp_pulses <= resp_pulses + 1;
  end

  // ---------------- reference model: byte-addressed memory ----------------
  logic [7:0]  ref_b [512];
  logic [63:0] exp_q [$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wdata;
  } op_t;

  function automatic logic [63:0] ref_dword(input int a);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_b[(a / 8) * 8 + i];
    return v;
  endfunction

  // Computes the expected outcome of one access and applies stores to ref_b
  task automatic ref_op(input op_t op, output logic [63:0] e_rdata, output logic e_mis,
                        output int e_lat, output int e_rd_n, output int e_rd_k,
                        output int e_wr_n, output int e_wr_k, output logic [63:0] e_wdata);
    int n;
    int a;
    n = 1 << op.size;
    a = int'(op.addr[8:0]);
    e_mis = (a % n) != 0;
    e_rdata = 64'd0; e_wdata = 64'd0;
    e_rd_n = 0; e_rd_k = -1; e_wr_n = 0; e_wr_k = -1;
    if (e_mis) begin
      e_lat = 1;
    end else if (!op.we) begin
      for (int i = 0; i < n; i++) e_rdata[8*i +: 8] = ref_b[a + i];
      if (!op.uns && n < 8 && e_rdata[8*n-1])
        for (int i = n; i < 8; i++) e_rdata[8*i +: 8] = 8'hFF;
      e_lat = 3; e_rd_n = 1; e_rd_k = 1;
    end else begin
      for (int i = 0; i < n; i++) ref_b[a + i] = op.wdata[8*i +: 8];
      e_wdata = ref_dword(a);
      e_wr_n = 1;
      if (n == 8) begin
        e_lat = 2; e_wr_k = 1;
      end else begin
        e_lat = 4; e_wr_k = 3; e_rd_n = 1; e_rd_k = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic init_mem();
    logic [63:0] d;
    for (int i = 0; i < 64; i++) begin
      d = {$urandom, $urandom};
      if (i == 32) d = 64'hF0E1_D2C3_B4A5_9687;
      init_img[i] = d;
      for (int j = 0; j < 8; j++) ref_b[i*8 + j] = d[8*j +: 8];
    end
    load_img = 1'b1;
    @(negedge clk);
    load_img = 1'b0;
  endtask

  int          o_resp_k, o_rd_k, o_rd_n, o_wr_k, o_wr_n;
  logic [63:0] o_rdata, o_wr_data;
  logic        o_mis, o_addr_bad, o_ready_bad;

  // Issues one request at a negedge and records what the DUT does, cycle by cycle
  task automatic run_op(input op_t op);
    o_resp_k = -1; o_rd_k = -1; o_rd_n = 0; o_wr_k = -1; o_wr_n = 0;
    o_rdata = 64'hDEAD; o_wr_data = 64'd0; o_mis = 1'bx;
    o_addr_bad = 1'b0; o_ready_bad = 1'b0;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    req_valid = 1'b1; req_we = op.we; req_size = op.size; req_unsigned = op.uns;
    req_addr = op.addr; req_wdata = op.wdata;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
      end
      if (mem_rd_en) begin o_rd_n++; o_rd_k = k; end
      if (mem_wr_en) begin o_wr_n++; o_wr_k = k; o_wr_data = mem_wr_data; end
      if ((mem_rd_en || mem_wr_en) && mem_addr !== {op.addr[31:3], 3'b000}) o_addr_bad = 1'b1;
      if (o_resp_k >= 0 && k == o_resp_k + 1) begin
        if (req_ready !== 1'b1) o_ready_bad = 1'b1;
        break;
      end
      if (resp_valid && o_resp_k < 0) begin
        o_resp_k = k; o_rdata = resp_rdata; o_mis = resp_misalign;
      end
      if (req_ready !== 1'b0) o_ready_bad = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 64'd0; mem_rd_data = 64'd0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({req_ready, resp_valid, resp_misalign, mem_rd_en, mem_wr_en} !== 5'b0)
      $display("FAIL reset_ctrl got=%b want=00000",
               {req_ready, resp_valid, resp_misalign, mem_rd_en, mem_wr_en});
    else pass_cnt++;
    chk_cnt++;
    if ({resp_rdata, mem_wr_data, mem_addr} !== 160'd0)
      $display("FAIL reset_data rdata=%h wdata=%h addr=%h want=0", resp_rdata, mem_wr_data, mem_addr);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    op_t ops [12];
    logic [63:0] want [12];
    logic [63:0] e_rdata, e_wdata;
    logic e_mis;
    int e_lat, e_rd_n, e_rd_k, e_wr_n, e_wr_k, bad;
    ops[0]  = '{1'b0, 2'b00, 1'b0, 32'h100, 64'd0};                 // LB
    ops[1]  = '{1'b0, 2'b00, 1'b1, 32'h100, 64'd0};                 // LBU
    ops[2]  = '{1'b0, 2'b01, 1'b0, 32'h102, 64'd0};                 // LH
    ops[3]  = '{1'b0, 2'b10, 1'b1, 32'h104, 64'd0};                 // LWU
    ops[4]  = '{1'b0, 2'b11, 1'b0, 32'h100, 64'd0};                 // LD
    ops[5]  = '{1'b1, 2'b00, 1'b0, 32'h103, 64'h5A};                // SB
    ops[6]  = '{1'b0, 2'b11, 1'b0, 32'h100, 64'd0};                 // LD
    ops[7]  = '{1'b1, 2'b11, 1'b0, 32'h100, 64'h1122334455667788};  // SD
    ops[8]  = '{1'b0, 2'b11, 1'b0, 32'h100, 64'd0};                 // LD
    ops[9]  = '{1'b0, 2'b10, 1'b0, 32'h102, 64'd0};                 // LW mis
    ops[10] = '{1'b1, 2'b01, 1'b0, 32'h101, 64'hBEEF};              // SH mis
    ops[11] = '{1'b1, 2'b11, 1'b0, 32'h104, 64'hCAFE};              // SD mis
    want = '{64'hFFFFFFFFFFFFFF87, 64'h87, 64'hFFFFFFFFFFFFB4A5, 64'hF0E1D2C3,
             64'hF0E1D2C3B4A59687, 64'd0, 64'hF0E1D2C35AA59687, 64'd0,
             64'h1122334455667788, 64'd0, 64'd0, 64'd0};
    for (int i = 0; i < 12; i++) begin
      ref_op(ops[i], e_rdata, e_mis, e_lat, e_rd_n, e_rd_k, e_wr_n, e_wr_k, e_wdata);
      run_op(ops[i]);
      chk_cnt++;
      if (o_resp_k !== e_lat) $display("FAIL dir%0d_latency got=%0d want=%0d", i, o_resp_k, e_lat);
      else pass_cnt++;
      chk_cnt++;
      if (o_rdata !== want[i]) $display("FAIL dir%0d_rdata got=%h want=%h", i, o_rdata, want[i]);
      else pass_cnt++;
      chk_cnt++;
      if (o_mis !== e_mis) $display("FAIL dir%0d_misalign got=%b want=%b", i, o_mis, e_mis);
      else pass_cnt++;
      chk_cnt++;
      if (o_rd_n !== e_rd_n || o_rd_k !== e_rd_k)
        $display("FAIL dir%0d_rd_strobe got=%0d@%0d want=%0d@%0d", i, o_rd_n, o_rd_k, e_rd_n, e_rd_k);
      else pass_cnt++;
      chk_cnt++;
      if (o_wr_n !== e_wr_n || o_wr_k !== e_wr_k || o_wr_data !== e_wdata)
        $display("FAIL dir%0d_write got=%0d@%0d %h want=%0d@%0d %h",
                 i, o_wr_n, o_wr_k, o_wr_data, e_wr_n, e_wr_k, e_wdata);
      else pass_cnt++;
      chk_cnt++;
      if (o_addr_bad || o_ready_bad)
        $display("FAIL dir%0d_addr_ready got=%b%b want=00", i, o_addr_bad, o_ready_bad);
      else pass_cnt++;
    end
    bad = 0;
    for (int d = 0; d < 64; d++) if (dmem[d] !== ref_dword(d * 8)) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL dir_memory got=%0d bad dwords want=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    op_t ld;
    int wr0, rsp0, bad;
    ld = '{1'b0, 2'b11, 1'b0, 32'h100, 64'd0};
    run_op(ld);   // leaves a nonzero resp_rdata behind
    wr0 = wr_strobes; rsp0 = resp_pulses;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h106; req_wdata = 64'hBEEF;
    @(negedge clk);            // RD_REQ
    req_valid = 1'b0;
    @(negedge clk);            // RD_DATA
    rst = 1'b1;
    @(negedge clk);            // cycle after rst sampled
    chk_cnt++;
    if ({resp_valid, resp_misalign, mem_rd_en, mem_wr_en, req_ready} !== 5'b0)
      $display("FAIL midrst_ctrl got=%b want=00000",
               {resp_valid, resp_misalign, mem_rd_en, mem_wr_en, req_ready});
    else pass_cnt++;
    chk_cnt++;
    if ({resp_rdata, mem_wr_data, mem_addr} !== 160'd0)
      $display("FAIL midrst_data rdata=%h wdata=%h addr=%h want=0", resp_rdata, mem_wr_data, mem_addr);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL midrst_ready got=%b want=1", req_ready);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (wr_strobes != wr0 || resp_pulses != rsp0)
      $display("FAIL midrst_no_activity got wr=%0d resp=%0d want 0 0", wr_strobes - wr0, resp_pulses - rsp0);
    else pass_cnt++;
    bad = 0;
    for (int d = 0; d < 64; d++) if (dmem[d] !== ref_dword(d * 8)) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL midrst_memory got=%0d bad dwords want=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    op_t o1, o2;
    logic [63:0] e_rdata, e_wdata, got;
    logic e_mis;
    int e_lat1, e_lat2, e_rd_n, e_rd_k, e_wr_n, e_wr_k;
    int acc2, resp1_k, resp2_k, ready_bad, n_resp;
    o1 = '{1'b0, 2'b11, 1'b0, 32'h100, 64'd0};
    o2 = '{1'b0, 2'b00, 1'b0, 32'h107, 64'd0};
    ref_op(o1, e_rdata, e_mis, e_lat1, e_rd_n, e_rd_k, e_wr_n, e_wr_k, e_wdata);
    exp_q.push_back(e_rdata);
    ref_op(o2, e_rdata, e_mis, e_lat2, e_rd_n, e_rd_k, e_wr_n, e_wr_k, e_wdata);
    exp_q.push_back(e_rdata);
    acc2 = e_lat1 + 1;
    resp1_k = -1; resp2_k = -1; ready_bad = 0; n_resp = 0;
    req_valid = 1'b1; req_we = o1.we; req_size = o1.size; req_unsigned = o1.uns;
    req_addr = o1.addr; req_wdata = o1.wdata;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (req_ready !== ((k == acc2) || (k > acc2 + e_lat2))) ready_bad++;
      if (resp_valid) begin
        n_resp++;
        if (resp1_k < 0) resp1_k = k; else if (resp2_k < 0) resp2_k = k;
        got = resp_rdata;
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra_resp got=%h at %0d want=none", got, k);
        else if (got !== exp_q[0]) $display("FAIL b2b_rdata got=%h want=%h", got, exp_q.pop_front());
        else begin void'(exp_q.pop_front()); pass_cnt++; end
      end
      if (k == 1) begin
        req_we = o2.we; req_size = o2.size; req_unsigned = o2.uns;
        req_addr = o2.addr; req_wdata = o2.wdata;
      end
      if (k == acc2 + 1) req_valid = 1'b0;
    end
    chk_cnt++;
    if (resp1_k != e_lat1 || resp2_k != acc2 + e_lat2)
      $display("FAIL b2b_timing got=%0d,%0d want=%0d,%0d", resp1_k, resp2_k, e_lat1, acc2 + e_lat2);
    else pass_cnt++;
    chk_cnt++;
    if (ready_bad != 0 || n_resp != 2 || exp_q.size() != 0)
      $display("FAIL b2b_ready got bad=%0d resps=%0d left=%0d want 0 2 0", ready_bad, n_resp, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_random();
    op_t op;
    logic [63:0] e_rdata, e_wdata;
    logic e_mis;
    int e_lat, e_rd_n, e_rd_k, e_wr_n, e_wr_k, bad, n;
    for (int i = 0; i < 120; i++) begin
      op.we    = 1'($urandom_range(0, 1));
      op.size  = 2'($urandom_range(0, 3));
      op.uns   = 1'($urandom_range(0, 1));
      op.addr  = {$urandom_range(0, 15) == 0 ? 23'($urandom) : 23'd0, 9'($urandom_range(0, 511))};
      n = 1 << op.size;
      if ($urandom_range(0, 3) != 0) op.addr[2:0] = op.addr[2:0] & 3'(~(n - 1));
      op.wdata = {$urandom, $urandom};
      ref_op(op, e_rdata, e_mis, e_lat, e_rd_n, e_rd_k, e_wr_n, e_wr_k, e_wdata);
      run_op(op);
      chk_cnt++;
      if (o_resp_k !== e_lat) $display("FAIL rnd%0d_latency got=%0d want=%0d", i, o_resp_k, e_lat);
      else pass_cnt++;
      chk_cnt++;
      if (o_rdata !== e_rdata || o_mis !== e_mis)
        $display("FAIL rnd%0d_resp got=%h/%b want=%h/%b", i, o_rdata, o_mis, e_rdata, e_mis);
      else pass_cnt++;
      chk_cnt++;
      if (o_rd_n !== e_rd_n || o_rd_k !== e_rd_k)
        $display("FAIL rnd%0d_rd_strobe got=%0d@%0d want=%0d@%0d", i, o_rd_n, o_rd_k, e_rd_n, e_rd_k);
      else pass_cnt++;
      chk_cnt++;
      if (o_wr_n !== e_wr_n || o_wr_k !== e_wr_k || o_wr_data !== e_wdata)
        $display("FAIL rnd%0d_write got=%0d@%0d %h want=%0d@%0d %h",
                 i, o_wr_n, o_wr_k, o_wr_data, e_wr_n, e_wr_k, e_wdata);
      else pass_cnt++;
      chk_cnt++;
      if (o_addr_bad || o_ready_bad)
        $display("FAIL rnd%0d_addr_ready got=%b%b want=00", i, o_addr_bad, o_ready_bad);
      else pass_cnt++;
    end
    bad = 0;
    for (int d = 0; d < 64; d++) if (dmem[d] !== ref_dword(d * 8)) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL rnd_memory got=%0d bad dwords want=0", bad);
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    init_mem();
    test_directed();
    init_mem();
    test_reset_mid_op();
    init_mem();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
# rv_lsu

Load/store unit for the MEM stage of the RV64 core. It sits directly upstream of `rv_data_mem` and turns one LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD request into doubleword-aligned accesses on that memory's 64-bit port. Loads get byte-lane extraction plus sign or zero extension. Sub-doubleword stores are done as read-modify-write, because the data memory has no byte enables. Misaligned accesses are flagged and never reach memory.

## Interface
Parameters: none.

Ports:
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request (idle and not in reset).
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 double.
- `req_unsigned` in 1: zero-extend load (LBU/LHU/LWU); ignored for double and for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 64: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 64: extended load data; 0 for stores and misaligned accesses.
- `resp_misalign` out 1: access was misaligned; qualified by `resp_valid`.
- `mem_addr` out 32: to data memory; always `{addr[31:3],3'b000}`.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rd_data` in 64: memory read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en` out 1: memory write strobe; the write takes effect at the end of the cycle.
- `mem_wr_data` out 64: full doubleword to write.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR, RESP. `req_ready` = (state==IDLE) & ~rst.
- IDLE, on `req_valid`:
  - Latch `req_*` into internal registers.
  - Misaligned → RESP with the misalign flag set. Misaligned means half with `addr[0]`≠0, word with `addr[1:0]`≠0, or double with `addr[2:0]`≠0.
  - Load → RD_REQ.
  - Doubleword store → WR with merge buffer = `wdata`.
  - Other store → RD_REQ.
- RD_REQ: `mem_rd_en`=1 → RD_DATA.
- RD_DATA: capture `mem_rd_data`, with off = `addr[2:0]`.
  - Load: shifted = rd >> (8·off). Take the low 8/16/32/64 bits, then sign-extend, or zero-extend if `unsigned`. Register the result into `resp_rdata`, then go to RESP.
  - Store: mask = lane mask of (1,2,4,8) bytes << off. merged = (rd & ~mask) | ((wdata << 8·off) & mask). Register merged into the buffer, then go to WR.
- WR: `mem_wr_en`=1, `mem_wr_data` = buffer → RESP.
- RESP: `resp_valid`=1 → IDLE. A new request can be accepted the cycle after RESP.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle, and are never high outside RD_REQ and WR respectively.
- `mem_addr` holds the latched aligned address in every non-IDLE state and is 0 in IDLE.
- `resp_rdata` and `resp_misalign` are registered and hold until the next response.

## Timing
- Reset (any state): the next state is IDLE.
  - Output values in the cycle after `rst` is sampled: `resp_valid`=0, `resp_rdata`=0, `resp_misalign`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0.
  - `req_ready`=1 in the first cycle with `rst` low.
- Reset mid-operation aborts the access. No pending write is issued, and no response is issued for the aborted request.
- Latency from the acceptance cycle A (IDLE & `req_valid`) to `resp_valid`:
  - load: A+3;
  - doubleword store: A+2, with the write in A+1;
  - sub-doubleword store: A+4, with the read in A+1 and the write in A+3;
  - misaligned: A+1.
- There is no response back-pressure: the consumer must accept `resp_valid` in the cycle it is high. Upstream stalls on `req_ready`.
- `req_*` need only be valid in the acceptance cycle.

## Test plan
Memory dword at 0x100 = 0xF0E1D2C3B4A59687 for all scenarios.
- Loads:
  - LB 0x100 → `resp_rdata`=0xFFFFFFFFFFFFFF87 at A+3, with `mem_rd_en` only at A+1 and `mem_addr`=0x100.
  - LBU 0x100 → 0x87.
  - LH 0x102 → 0xFFFFFFFFFFFFB4A5.
  - LWU 0x104 → 0xF0E1D2C3.
  - LD 0x100 → 0xF0E1D2C3B4A59687.
- SB 0x5A to 0x103 → `mem_wr_en` only at A+3 with `mem_wr_data`=0xF0E1D2C35AA59687. `resp_valid` at A+4 with `resp_rdata`=0. A following LD returns the new value.
- SD 0x1122334455667788 to 0x100 → no read strobe; write at A+1 with exact data; `resp_valid` at A+2.
- Misaligned accesses (LW 0x102, SH 0x101, SD 0x104) → `resp_valid`+`resp_misalign` at A+1, `resp_rdata`=0, no memory strobes, memory unchanged.
- SH 0xBEEF to 0x106 with `rst` asserted during RD_DATA → `mem_wr_en` never asserts, all outputs 0, `req_ready`=1 the cycle after `rst` deasserts, memory unchanged.
- `req_valid` held high for LD 0x100 then LB 0x107 → second accepted the cycle after the first RESP. Responses 0xF0E1D2C3B4A59687 then 0xFFFFFFFFFFFFFFF0; `req_ready`=0 in all intermediate cycles.
